// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-back scheduler.
package wb_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_CORE,
    SRC_MDU,
    SRC_LSU
  } src_t;

  localparam int STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/wb_scoreboard.sv
// Destination-register reservation bits for in-flight long operations.
// A set and a clear on the same index in one cycle leaves the bit set.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  reg_idx_t    set_idx,
  input  logic        clr_en,
  input  reg_idx_t    clr_idx,
  input  reg_idx_t    rd_idx_a,
  input  reg_idx_t    rd_idx_b,
  input  reg_idx_t    rd_idx_c,
  output logic        hit_a,
  output logic        hit_b,
  output logic        hit_c,
  output logic [31:0] pending
);

  logic [31:1] pend_reg;

  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_bit
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pend_reg[gi] <= 1'b0;
        end else if (set_en && (set_idx == reg_idx_t'(gi))) begin
          pend_reg[gi] <= 1'b1;
        end else if (clr_en && (clr_idx == reg_idx_t'(gi))) begin
          pend_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  // x0 is hard-wired to zero, so it can never be reserved or hazard.
  assign pending = {pend_reg, 1'b0};
  assign hit_a   = pending[rd_idx_a];
  assign hit_b   = pending[rd_idx_b];
  assign hit_c   = pending[rd_idx_c];

endmodule

// File: rtl/wb_scheduler.sv
// Shares the register-file write port between core, MDU and LSU, and stalls
// issue on RAW/WAW hazards against registers reserved by long operations.
module wb_scheduler
  import wb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  reg_idx_t        iss_rs1,
  input  reg_idx_t        iss_rs2,
  input  reg_idx_t        iss_rd,
  input  logic            iss_long,
  output logic            iss_stall,
  input  logic            core_wr_en,
  input  reg_idx_t        core_rd,
  input  logic [XLEN-1:0] core_wr_data,
  input  logic            mdu_valid,
  input  reg_idx_t        mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            mdu_ready,
  input  logic            lsu_valid,
  input  reg_idx_t        lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            rf_wr_en,
  output reg_idx_t        rf_rd,
  output logic [XLEN-1:0] rf_wr_data,
  output logic [31:0]     pending
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic          rr_reg;
  logic [CW-1:0] starve_cnt_reg;
  logic          hit_rs1, hit_rs2, hit_rd;
  logic          hz, force_grant, core_take, unit_hs, long_set;
  src_t          src;
  reg_idx_t      win_rd;
  logic [XLEN-1:0] win_data;

  assign hz          = iss_valid & (hit_rs1 | hit_rs2 | hit_rd);
  assign force_grant = (starve_cnt_reg == LIMIT);
  assign iss_stall   = hz | (iss_valid & force_grant);
  assign core_take   = core_wr_en & ~iss_stall;
  assign long_set    = iss_valid & ~iss_stall & iss_long & (iss_rd != '0);

  // Core first; otherwise round-robin, rr_reg = 1 favouring the LSU.
  always_comb begin
    src = SRC_NONE;
    if (core_take) begin
      src = SRC_CORE;
    end else if (mdu_valid && (!lsu_valid || !rr_reg)) begin
      src = SRC_MDU;
    end else if (lsu_valid) begin
      src = SRC_LSU;
    end
  end

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    case (src)
      SRC_CORE: begin win_rd = core_rd; win_data = core_wr_data; end
      SRC_MDU:  begin win_rd = mdu_rd;  win_data = mdu_data;     end
      SRC_LSU:  begin win_rd = lsu_rd;  win_data = lsu_data;     end
      default:  begin win_rd = '0;      win_data = '0;           end
    endcase
  end

  assign mdu_ready  = (src == SRC_MDU);
  assign lsu_ready  = (src == SRC_LSU);
  assign unit_hs    = mdu_ready | lsu_ready;
  assign rf_wr_en   = (src != SRC_NONE) && (win_rd != '0);
  assign rf_rd      = win_rd;
  assign rf_wr_data = win_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_reg         <= 1'b0;
      starve_cnt_reg <= '0;
    end else begin
      if (mdu_ready) begin
        rr_reg <= 1'b1;
      end else if (lsu_ready) begin
        rr_reg <= 1'b0;
      end
      if ((mdu_valid | lsu_valid) & core_take) begin
        if (starve_cnt_reg != LIMIT) begin
          starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
      end else begin
        starve_cnt_reg <= '0;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (long_set),
    .set_idx  (iss_rd),
    .clr_en   (unit_hs),
    .clr_idx  (win_rd),
    .rd_idx_a (iss_rs1),
    .rd_idx_b (iss_rs2),
    .rd_idx_c (iss_rd),
    .hit_a    (hit_rs1),
    .hit_b    (hit_rs2),
    .hit_c    (hit_rd),
    .pending  (pending)
  );

endmodule

// File: tb/tb_wb_scheduler.sv
// Randomised and directed scenarios for wb_scheduler, checked through an
// expectation queue drained by an independent monitor.
module tb_wb_scheduler;
  import wb_pkg::*;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_long, iss_stall;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        core_wr_en;
  logic [4:0]  core_rd;
  logic [31:0] core_wr_data;
  logic        mdu_valid, mdu_ready, lsu_valid, lsu_ready;
  logic [4:0]  mdu_rd, lsu_rd;
  logic [31:0] mdu_data, lsu_data;
  logic        rf_wr_en;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wr_data;
  logic [31:0] pending;

  always #5 clk = ~clk;

  wb_scheduler #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_long(iss_long), .iss_stall(iss_stall),
    .core_wr_en(core_wr_en), .core_rd(core_rd), .core_wr_data(core_wr_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wr_en(rf_wr_en), .rf_rd(rf_rd), .rf_wr_data(rf_wr_data), .pending(pending)
  );

  typedef struct {
    logic        stall, mrdy, lrdy, wen;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic [31:0] pend;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] mdu_q[$];
  logic [4:0] lsu_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference state: reserved registers, consecutive lost cycles, preferred unit.
  logic [31:0] m_pend = '0;
  int          m_cnt = 0;
  bit          m_pref_lsu = 0;
  bit          last_stall, last_mg, last_lg, last_acc;
  logic [4:0]  last_acc_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("iss_stall", 32'(iss_stall), 32'(e.stall));
        chk("mdu_ready", 32'(mdu_ready), 32'(e.mrdy));
        chk("lsu_ready", 32'(lsu_ready), 32'(e.lrdy));
        chk("rf_wr_en", 32'(rf_wr_en), 32'(e.wen));
        chk("rf_rd", 32'(rf_rd), 32'(e.wrd));
        chk("rf_wr_data", rf_wr_data, e.wdata);
        chk("pending", pending, e.pend);
        $display("cyc %0d stall=%b mrdy=%b lrdy=%b wen=%b rd=%0d data=%h pend=%h",
                 cyc, iss_stall, mdu_ready, lsu_ready, rf_wr_en, rf_rd, rf_wr_data, pending);
      end
    end
  end

  task automatic idle();
    iss_valid = 0; iss_long = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
    core_wr_en = 0; core_rd = 0; core_wr_data = 0;
    mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  // Predict this cycle's outputs from the rules, then advance the model at the edge.
  task automatic step();
    exp_t e;
    bit hz, frc, stall, ctake, mg, lg, any_unit;
    logic [31:0] np;
    hz    = iss_valid && (m_pend[iss_rs1] || m_pend[iss_rs2] || m_pend[iss_rd]);
    frc   = (m_cnt == LIMIT);
    stall = hz || (iss_valid && frc);
    ctake = core_wr_en && !stall;
    mg = 0; lg = 0;
    if (!ctake) begin
      if (mdu_valid && lsu_valid) begin
        if (m_pref_lsu) lg = 1; else mg = 1;
      end else if (mdu_valid) mg = 1;
      else if (lsu_valid) lg = 1;
    end
    e.stall = stall; e.mrdy = mg; e.lrdy = lg;
    e.wrd = 0; e.wdata = 0; e.pend = m_pend;
    if (ctake)   begin e.wrd = core_rd; e.wdata = core_wr_data; end
    else if (mg) begin e.wrd = mdu_rd;  e.wdata = mdu_data;     end
    else if (lg) begin e.wrd = lsu_rd;  e.wdata = lsu_data;     end
    e.wen = (ctake || mg || lg) && (e.wrd != 0);
    exp_q.push_back(e);

    np = m_pend;
    if (mg) np[mdu_rd] = 1'b0;
    if (lg) np[lsu_rd] = 1'b0;
    last_acc = iss_valid && !stall && iss_long;
    last_acc_rd = iss_rd;
    if (last_acc && iss_rd != 0) np[iss_rd] = 1'b1;
    np[0] = 1'b0;
    any_unit = mdu_valid || lsu_valid;
    last_stall = stall; last_mg = mg; last_lg = lg;

    @(posedge clk);
    cyc++;
    m_pend = np;
    if (any_unit && ctake) m_cnt = (m_cnt < LIMIT) ? m_cnt + 1 : LIMIT;
    else m_cnt = 0;
    if (mg) m_pref_lsu = 1;
    else if (lg) m_pref_lsu = 0;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    m_pend = '0; m_cnt = 0; m_pref_lsu = 0;
    last_stall = 0; last_mg = 0; last_lg = 0; last_acc = 0;
    mdu_q.delete(); lsu_q.delete();
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    if (last_acc) begin
      if ($urandom_range(0, 1) == 0) mdu_q.push_back(last_acc_rd);
      else lsu_q.push_back(last_acc_rd);
    end
    if (!last_stall) begin
      iss_valid    = ($urandom_range(0, 3) != 0);
      iss_rs1      = 5'($urandom_range(0, 11));
      iss_rs2      = 5'($urandom_range(0, 11));
      iss_rd       = 5'($urandom_range(0, 11));
      iss_long     = ($urandom_range(0, 2) == 0);
      core_wr_en   = ($urandom_range(0, 1) == 1);
      core_rd      = 5'($urandom_range(0, 31));
      core_wr_data = $urandom;
    end
    if (last_mg) begin void'(mdu_q.pop_front()); mdu_valid = 0; end
    if (!mdu_valid && mdu_q.size() > 0 && $urandom_range(0, 1) == 1) begin
      mdu_valid = 1; mdu_rd = mdu_q[0]; mdu_data = $urandom;
    end
    if (last_lg) begin void'(lsu_q.pop_front()); lsu_valid = 0; end
    if (!lsu_valid && lsu_q.size() > 0 && $urandom_range(0, 1) == 1) begin
      lsu_valid = 1; lsu_rd = lsu_q[0]; lsu_data = $urandom;
    end
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #2;
    chk("rst_pending", pending, 32'h0);
    chk("rst_stall", 32'(iss_stall), 32'h0);
    chk("rst_wr_en", 32'(rf_wr_en), 32'h0);
    chk("rst_readies", 32'({mdu_ready, lsu_ready}), 32'h0);
    do_reset();

    // Core write is visible on the write port in the same cycle.
    idle(); core_wr_en = 1; core_rd = 5; core_wr_data = 32'h1234;
    #1;
    chk("core_rf_rd", 32'(rf_rd), 32'd5);
    chk("core_rf_data", rf_wr_data, 32'h0000_1234);
    step();

    // RAW on a reserved register, released by the MDU result.
    idle(); iss_valid = 1; iss_long = 1; iss_rd = 7; iss_rs1 = 1; iss_rs2 = 2;
    step();
    idle(); iss_valid = 1; iss_rs1 = 7; iss_rd = 8;
    step();
    mdu_valid = 1; mdu_rd = 7; mdu_data = 32'hCAFE_0007;
    step();
    mdu_valid = 0;
    step();

    // Round-robin from reset with both units valid and the core idle.
    do_reset();
    idle(); mdu_valid = 1; mdu_rd = 10; mdu_data = 32'hAAAA; lsu_valid = 1; lsu_rd = 11; lsu_data = 32'hBBBB;
    repeat (4) step();

    // Core keeps the port until the starvation limit forces a stall.
    idle(); iss_valid = 1; iss_rd = 1; core_wr_en = 1; core_rd = 1; core_wr_data = 32'h55;
    lsu_valid = 1; lsu_rd = 12; lsu_data = 32'h77;
    repeat (LIMIT) step();
    #1;
    chk("starve_stall", 32'(iss_stall), 32'h1);
    chk("starve_lsu_ready", 32'(lsu_ready), 32'h1);
    step();

    // Same-cycle retire and reservation of one register: the reservation stays.
    idle(); mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h99;
    iss_valid = 1; iss_long = 1; iss_rd = 9;
    step();
    idle();
    step();

    // rd = 0 neither reserves nor writes.
    idle(); iss_valid = 1; iss_long = 1; iss_rd = 0;
    step();
    idle(); lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hDEAD;
    #1;
    chk("x0_lsu_ready", 32'(lsu_ready), 32'h1);
    chk("x0_wr_en", 32'(rf_wr_en), 32'h0);
    step();

    do_reset();
    idle();
    repeat (1500) begin
      rand_inputs();
      step();
    end

    // Asynchronous reset mid-cycle with a reservation outstanding.
    idle();
    repeat (2) step();
    iss_valid = 1; iss_long = 1; iss_rd = 25;
    step();
    idle();
    chk("pre_rst_pending25", 32'(pending[25]), 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_pending", pending, 32'h0);
    do_reset();
    idle();
    step();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
